// File: rtl/awg_uart_pkg.sv
// Shared definitions for the UART command path into the AWG core: frame codes,
// parser state encodings and the configuration register address map.
package awg_uart_pkg;

    localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;

    localparam logic [7:0] CMD_WRITE_REG  = 8'h01;
    localparam logic [7:0] CMD_WRITE_WAVE = 8'h02;
    localparam logic [7:0] CMD_SET_RUN    = 8'h03;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CMD    = 4'd1;
    localparam logic [3:0] ST_REG_A  = 4'd2;
    localparam logic [3:0] ST_REG_DH = 4'd3;
    localparam logic [3:0] ST_REG_DL = 4'd4;
    localparam logic [3:0] ST_WAV_AH = 4'd5;
    localparam logic [3:0] ST_WAV_AL = 4'd6;
    localparam logic [3:0] ST_WAV_N  = 4'd7;
    localparam logic [3:0] ST_WAV_DH = 4'd8;
    localparam logic [3:0] ST_WAV_DL = 4'd9;
    localparam logic [3:0] ST_RUN_V  = 4'd10;
    localparam logic [3:0] ST_CHK    = 4'd11;

    // AWG core configuration register map (targets of WRITE_REG)
    localparam logic [7:0] CFG_CTRL       = 8'h00;
    localparam logic [7:0] CFG_WAVE_LEN   = 8'h04;
    localparam logic [7:0] CFG_PHASE_STEP = 8'h10;
    localparam logic [7:0] CFG_AMPLITUDE  = 8'h14;
    localparam logic [7:0] CFG_OFFSET     = 8'h18;

endpackage

// File: rtl/uart_cmd_watchdog.sv
// Inter-byte timeout for the command parser: a down-counter reloaded on every
// kick (and while disabled); expire is asserted when it hits zero with no kick.
module uart_cmd_watchdog #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (!en || kick) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout
    assign expire = en && !kick && (cnt == '0);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Framed command parser between the UART receiver and the AWG register/RAM ports.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for SYNC byte, other bytes ignored
// CMD       | expecting command code
// REG_A     | WRITE_REG: register address
// REG_DH/DL | WRITE_REG: data high / low byte
// WAV_AH/AL | WRITE_WAVE: start address high / low byte
// WAV_N     | WRITE_WAVE: sample count (0 = 256)
// WAV_DH/DL | WRITE_WAVE: sample high / low byte, written on DL
// RUN_V     | SET_RUN: run value
// CHK       | checksum byte, commits REG/RUN payload on match
module uart_cmd_sequencer
    import awg_uart_pkg::*;
#(
    parameter int         WAVE_AW     = 12,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               cfg_we,
    output logic [7:0]         cfg_addr,
    output logic [15:0]        cfg_wdata,
    output logic               wave_we,
    output logic [WAVE_AW-1:0] wave_addr,
    output logic [15:0]        wave_wdata,
    output logic               run,
    output logic               busy,
    output logic               frame_ok,
    output logic               frame_err
);

    logic [3:0]         state;
    logic [7:0]         cmd;
    logic [7:0]         chk_acc;
    logic [7:0]         pend_addr;
    logic [15:0]        pend_data;
    logic               pend_run;
    logic [7:0]         wav_ah;
    logic [7:0]         wav_dh;
    logic [8:0]         wav_cnt;
    logic [WAVE_AW-1:0] wave_ptr;
    logic               timeout_hit;

    assign busy = (state != ST_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (busy),
        .kick   (rx_valid),
        .expire (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd        <= '0;
            chk_acc    <= '0;
            pend_addr  <= '0;
            pend_data  <= '0;
            pend_run   <= 1'b0;
            wav_ah     <= '0;
            wav_dh     <= '0;
            wav_cnt    <= '0;
            wave_ptr   <= '0;
            cfg_we     <= 1'b0;
            cfg_addr   <= '0;
            cfg_wdata  <= '0;
            wave_we    <= 1'b0;
            wave_addr  <= '0;
            wave_wdata <= '0;
            run        <= 1'b0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cfg_we    <= 1'b0;
            wave_we   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (rx_valid) begin
                if (state != ST_IDLE && state != ST_CHK) begin
                    chk_acc <= chk_acc + rx_data;
                end
                case (state)
                    ST_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state   <= ST_CMD;
                            chk_acc <= '0;
                        end
                    end
                    ST_CMD: begin
                        cmd <= rx_data;
                        case (rx_data)
                            CMD_WRITE_REG:  state <= ST_REG_A;
                            CMD_WRITE_WAVE: state <= ST_WAV_AH;
                            CMD_SET_RUN:    state <= ST_RUN_V;
                            default: begin
                                state     <= ST_IDLE;
                                frame_err <= 1'b1;
                            end
                        endcase
                    end
                    ST_REG_A: begin
                        pend_addr <= rx_data;
                        state     <= ST_REG_DH;
                    end
                    ST_REG_DH: begin
                        pend_data[15:8] <= rx_data;
                        state           <= ST_REG_DL;
                    end
                    ST_REG_DL: begin
                        pend_data[7:0] <= rx_data;
                        state          <= ST_CHK;
                    end
                    ST_WAV_AH: begin
                        wav_ah <= rx_data;
                        state  <= ST_WAV_AL;
                    end
                    ST_WAV_AL: begin
                        wave_ptr <= WAVE_AW'({wav_ah, rx_data});
                        state    <= ST_WAV_N;
                    end
                    ST_WAV_N: begin
                        wav_cnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        state   <= ST_WAV_DH;
                    end
                    ST_WAV_DH: begin
                        wav_dh <= rx_data;
                        state  <= ST_WAV_DL;
                    end
                    ST_WAV_DL: begin
                        // Samples commit immediately; a later checksum failure cannot undo them
                        wave_we    <= 1'b1;
                        wave_addr  <= wave_ptr;
                        wave_wdata <= {wav_dh, rx_data};
                        wave_ptr   <= wave_ptr + WAVE_AW'(1);
                        wav_cnt    <= wav_cnt - 9'd1;
                        state      <= (wav_cnt == 9'd1) ? ST_CHK : ST_WAV_DH;
                    end
                    ST_RUN_V: begin
                        pend_run <= rx_data[0];
                        state    <= ST_CHK;
                    end
                    ST_CHK: begin
                        state <= ST_IDLE;
                        if (rx_data == chk_acc) begin
                            frame_ok <= 1'b1;
                            if (cmd == CMD_WRITE_REG) begin
                                cfg_we    <= 1'b1;
                                cfg_addr  <= pend_addr;
                                cfg_wdata <= pend_data;
                            end
                            if (cmd == CMD_SET_RUN) begin
                                run <= pend_run;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (timeout_hit) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer: per-byte vector table plus hand-written
// sequences for 256-sample frames, async reset mid-frame and (optionally) timeout.
module tb_uart_cmd_sequencer;

    localparam int WAVE_AW = 12;
    localparam int TB_TO   = 40;

    logic               clk;
    logic               rst_n;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               cfg_we;
    logic [7:0]         cfg_addr;
    logic [15:0]        cfg_wdata;
    logic               wave_we;
    logic [WAVE_AW-1:0] wave_addr;
    logic [15:0]        wave_wdata;
    logic               run;
    logic               busy;
    logic               frame_ok;
    logic               frame_err;

    uart_cmd_sequencer #(
        .WAVE_AW     (WAVE_AW),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .wave_we    (wave_we),
        .wave_addr  (wave_addr),
        .wave_wdata (wave_wdata),
        .run        (run),
        .busy       (busy),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        cfg_we;
        logic        wave_we;
        logic        ok;
        logic        err;
        logic        run;
        logic        busy;
        logic [15:0] addr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic [7:0] d, input logic cw, input logic ww, input logic ok,
                     input logic err, input logic r, input logic b,
                     input logic [15:0] a, input logic [15:0] wd);
        vec_t t;
        t.data = d; t.cfg_we = cw; t.wave_we = ww; t.ok = ok; t.err = err;
        t.run = r; t.busy = b; t.addr = a; t.wdata = wd;
        vecs.push_back(t);
    endtask

    // Byte is consumed on the next rising edge; outputs sampled 1 time unit later
    task automatic send_byte(input logic [7:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wcnt;
        int k;
        logic [WAVE_AW-1:0] last_addr;
        logic [7:0] d;

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        #12;
        check("reset cfg_we",    {31'd0, cfg_we},    32'd0);
        check("reset wave_we",   {31'd0, wave_we},   32'd0);
        check("reset run",       {31'd0, run},       32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset frame_ok",  {31'd0, frame_ok},  32'd0);
        check("reset frame_err", {31'd0, frame_err}, 32'd0);
        check("reset cfg_addr",  {24'd0, cfg_addr},  32'd0);
        rst_n = 1'b1;
        idle_cycle();

        // data  cfg_we wave_we ok err run busy addr wdata
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h10, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h12, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h34, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h57, 1,0,1,0, 0,0, 16'h0010, 16'h1234);
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h10, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h12, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h34, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h00, 0,0,0,1, 0,0, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h02, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h0F, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'hFF, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h02, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'hAA, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'hBB, 0,1,0,0, 0,1, 16'h0FFF, 16'hAABB);
        v(8'hCC, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'hDD, 0,1,0,0, 0,1, 16'h0000, 16'hCCDD);
        v(8'h20, 0,0,1,0, 0,0, 16'h0,    16'h0);
        v(8'h55, 0,0,0,0, 0,0, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h03, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h04, 0,0,1,0, 1,0, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h03, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h00, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h03, 0,0,1,0, 0,0, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h07, 0,0,0,1, 0,0, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h03, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 0,1, 16'h0,    16'h0);
        v(8'h04, 0,0,1,0, 1,0, 16'h0,    16'h0);
        // SYNC value used as payload: 01+A5+A5+A5 = F0
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'hF0, 1,0,1,0, 1,0, 16'h00A5, 16'hA5A5);
        // Bad checksum on wave frame: sample stays written, only frame_err
        v(8'hA5, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h02, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h00, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h05, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h01, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h11, 0,0,0,0, 1,1, 16'h0,    16'h0);
        v(8'h22, 0,1,0,0, 1,1, 16'h0005, 16'h1122);
        v(8'h00, 0,0,0,1, 1,0, 16'h0,    16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].data);
            check($sformatf("vec%0d cfg_we", i),    {31'd0, cfg_we},    {31'd0, vecs[i].cfg_we});
            check($sformatf("vec%0d wave_we", i),   {31'd0, wave_we},   {31'd0, vecs[i].wave_we});
            check($sformatf("vec%0d frame_ok", i),  {31'd0, frame_ok},  {31'd0, vecs[i].ok});
            check($sformatf("vec%0d frame_err", i), {31'd0, frame_err}, {31'd0, vecs[i].err});
            check($sformatf("vec%0d run", i),       {31'd0, run},       {31'd0, vecs[i].run});
            check($sformatf("vec%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].busy});
            if (vecs[i].cfg_we) begin
                check($sformatf("vec%0d cfg_addr", i),  {24'd0, cfg_addr},  {16'd0, vecs[i].addr});
                check($sformatf("vec%0d cfg_wdata", i), {16'd0, cfg_wdata}, {16'd0, vecs[i].wdata});
            end
            if (vecs[i].wave_we) begin
                check($sformatf("vec%0d wave_addr", i),  {20'd0, wave_addr}, {16'd0, vecs[i].addr});
                check($sformatf("vec%0d wave_wdata", i), {16'd0, wave_wdata}, {16'd0, vecs[i].wdata});
            end
            idle_cycle();
            check($sformatf("vec%0d strobes cleared", i),
                  {28'd0, cfg_we, wave_we, frame_ok, frame_err}, 32'd0);
        end

        // N=0 means 256 samples from 0x010; samples {i,00}: chk = 02+00+10+00+sum(0..255) = 0x92
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h00);
        wcnt      = 0;
        last_addr = '0;
        for (int i = 0; i < 256; i++) begin
            d = 8'(i);
            send_byte(d);
            send_byte(8'h00);
            if (wave_we) begin
                wcnt++;
                last_addr = wave_addr;
                if (wave_wdata !== {d, 8'h00}) begin
                    check($sformatf("n256 sample%0d data", i), {16'd0, wave_wdata}, {16'd0, d, 8'h00});
                end
            end
        end
        check("n256 sample count", wcnt, 32'd256);
        check("n256 last addr", {20'd0, last_addr}, 32'h10F);
        check("n256 still busy before chk", {31'd0, busy}, 32'd1);
        send_byte(8'h92);
        check("n256 frame_ok", {31'd0, frame_ok}, 32'd1);
        check("n256 frame_err", {31'd0, frame_err}, 32'd0);
        check("n256 busy after chk", {31'd0, busy}, 32'd0);
        idle_cycle();

        // Async reset mid-frame with run=1
        check("pre-reset run", {31'd0, run}, 32'd1);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset run", {31'd0, run}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h04);
        check("post-reset run", {31'd0, run}, 32'd1);
        check("post-reset frame_ok", {31'd0, frame_ok}, 32'd1);
        idle_cycle();

`ifdef UART_CMD_TIMEOUT_EN
        // Silence after A5 01: frame_err arrives TB_TO cycles after the last byte
        send_byte(8'hA5);
        send_byte(8'h01);
        k = 0;
        while (!frame_err && k < TB_TO + 10) begin
            idle_cycle();
            k++;
        end
        check("timeout frame_err seen", {31'd0, frame_err}, 32'd1);
        check("timeout latency", k, TB_TO);
        check("timeout busy", {31'd0, busy}, 32'd0);
        check("timeout run kept", {31'd0, run}, 32'd1);
        idle_cycle();
        check("timeout err pulse", {31'd0, frame_err}, 32'd0);
        // Bytes spaced just under the timeout keep the frame alive
        send_byte(8'hA5);
        send_byte(8'h03);
        for (int i = 0; i < TB_TO - 2; i++) idle_cycle();
        send_byte(8'h00);
        check("near-timeout busy", {31'd0, busy}, 32'd1);
        check("near-timeout no err", {31'd0, frame_err}, 32'd0);
        send_byte(8'h03);
        check("near-timeout run", {31'd0, run}, 32'd0);
        check("near-timeout frame_ok", {31'd0, frame_ok}, 32'd1);
        idle_cycle();
`else
        // Without the timeout the parser waits indefinitely mid-frame
        send_byte(8'hA5);
        send_byte(8'h03);
        k = 0;
        for (int i = 0; i < 3 * TB_TO; i++) begin
            idle_cycle();
            if (frame_err) k++;
        end
        check("no-timeout err count", k, 32'd0);
        check("no-timeout busy", {31'd0, busy}, 32'd1);
        send_byte(8'h00);
        send_byte(8'h03);
        check("no-timeout run", {31'd0, run}, 32'd0);
        check("no-timeout frame_ok", {31'd0, frame_ok}, 32'd1);
        idle_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
